// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame sequencer.
// Optional checksum byte is enabled by defining UART_FRAME_CHK_EN.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      S_HUNT,
      S_ID_HI,
      S_ID_LO,
      S_DLC,
      S_DATA,
      S_CHK,
      S_ISSUE
   } state_t;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_BAD_DLC  = 3'd1;
   localparam logic [2:0] ERR_CHECKSUM = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
   localparam logic [2:0] ERR_OVERRUN  = 3'd4;

   localparam logic [7:0] SYNC_DEFAULT = 8'hAA;
   localparam logic [3:0] MAX_DLC      = 4'd8;

   function automatic logic is_timed(state_t s);
      return (s == S_ID_HI) || (s == S_ID_LO) || (s == S_DLC) ||
             (s == S_DATA)  || (s == S_CHK);
   endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter for the UART frame sequencer.
// expired is high while enabled and the count sits at TIMEOUT_CYCLES-1.
module uart_frame_timeout #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   assign expired = enable && (count == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART byte stream to CAN frame request sequencer with error reporting.
// Define UART_FRAME_CHK_EN to require a trailing XOR checksum byte.
module uart_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [10:0] can_id,
   output logic [3:0]  can_dlc,
   output logic [63:0] can_data,
   output logic        err_pulse,
   output logic [2:0]  err_code,
   output logic        busy
);

`ifdef UART_FRAME_CHK_EN
   localparam state_t AFTER_DATA = S_CHK;
`else
   localparam state_t AFTER_DATA = S_ISSUE;
`endif

   state_t     state, state_next;
   logic       rx_q;
   logic       ev;
   logic [2:0] idx;
   logic       last_data;
   logic       expired;
   logic       err_set;
   logic [2:0] err_next;
   logic       tmo_clear;
   logic       tmo_en;

   assign ev          = rx_ready && !rx_q;
   assign last_data   = ({1'b0, idx} == (can_dlc - 4'd1));
   assign frame_valid = (state == S_ISSUE);
   assign busy        = (state != S_HUNT);
   assign tmo_en      = is_timed(state);
   assign tmo_clear   = ev || !tmo_en;

   uart_frame_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (tmo_clear),
      .enable (tmo_en),
      .expired(expired)
   );

`ifdef UART_FRAME_CHK_EN
   logic [7:0] acc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (ev) begin
         if (state == S_HUNT && rx_data == SYNC_BYTE) begin
            acc <= '0;
         end else if (state inside {S_ID_HI, S_ID_LO, S_DLC, S_DATA}) begin
            acc <= acc ^ rx_data;
         end
      end
   end
`endif

   always_comb begin
      state_next = state;
      err_set    = 1'b0;
      err_next   = ERR_NONE;
      unique case (state)
         S_HUNT: begin
            if (ev && rx_data == SYNC_BYTE) state_next = S_ID_HI;
         end
         S_ID_HI: begin
            if (ev) state_next = S_ID_LO;
         end
         S_ID_LO: begin
            if (ev) state_next = S_DLC;
         end
         S_DLC: begin
            if (ev) begin
               if (rx_data > {4'd0, MAX_DLC}) begin
                  err_set    = 1'b1;
                  err_next   = ERR_BAD_DLC;
                  state_next = S_HUNT;
               end else if (rx_data == 8'd0) begin
                  state_next = AFTER_DATA;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (ev && last_data) state_next = AFTER_DATA;
         end
`ifdef UART_FRAME_CHK_EN
         S_CHK: begin
            if (ev) begin
               if (rx_data == acc) begin
                  state_next = S_ISSUE;
               end else begin
                  err_set    = 1'b1;
                  err_next   = ERR_CHECKSUM;
                  state_next = S_HUNT;
               end
            end
         end
`endif
         S_ISSUE: begin
            if (frame_ready) state_next = S_HUNT;
            if (ev) begin
               err_set  = 1'b1;
               err_next = ERR_OVERRUN;
            end
         end
         default: state_next = S_HUNT;
      endcase
      // a byte arriving in the expiry cycle takes precedence
      if (expired && !ev) begin
         err_set    = 1'b1;
         err_next   = ERR_TIMEOUT;
         state_next = S_HUNT;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_HUNT;
         rx_q      <= 1'b0;
         idx       <= '0;
         can_id    <= '0;
         can_dlc   <= '0;
         can_data  <= '0;
         err_pulse <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         state     <= state_next;
         rx_q      <= rx_ready;
         err_pulse <= err_set;
         if (err_set) err_code <= err_next;
         if (ev) begin
            case (state)
               S_HUNT: begin
                  if (rx_data == SYNC_BYTE) can_data <= '0;
               end
               S_ID_HI: can_id[10:8] <= rx_data[2:0];
               S_ID_LO: can_id[7:0]  <= rx_data;
               S_DLC: begin
                  if (rx_data <= {4'd0, MAX_DLC}) begin
                     can_dlc <= rx_data[3:0];
                     idx     <= '0;
                  end
               end
               S_DATA: begin
                  can_data[{idx, 3'b000} +: 8] <= rx_data;
                  idx <= idx + 3'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed self-checking bench for uart_frame_ctrl.
// Checksum-dependent stimulus follows UART_FRAME_CHK_EN.
module tb_uart_frame_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready = 1'b0;
   logic        frame_valid;
   logic        frame_ready = 1'b1;
   logic [10:0] can_id;
   logic [3:0]  can_dlc;
   logic [63:0] can_data;
   logic        err_pulse;
   logic [2:0]  err_code;
   logic        busy;

   int tests = 0;
   int fails = 0;

   int          xfers = 0;
   int          vcyc = 0;
   int          errs = 0;
   int          stab = 0;
   logic [2:0]  last_code = '0;
   logic [10:0] x_id = '0;
   logic [3:0]  x_dlc = '0;
   logic [63:0] x_data = '0;
   logic        pv = 1'b0;
   logic [10:0] pid = '0;
   logic [3:0]  pdlc = '0;
   logic [63:0] pdata = '0;

   uart_frame_ctrl #(
      .TIMEOUT_CYCLES(50),
      .SYNC_BYTE     (8'hAA)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .can_id     (can_id),
      .can_dlc    (can_dlc),
      .can_data   (can_data),
      .err_pulse  (err_pulse),
      .err_code   (err_code),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      pv    <= frame_valid;
      pid   <= can_id;
      pdlc  <= can_dlc;
      pdata <= can_data;
      if (frame_valid && pv &&
          (can_id != pid || can_dlc != pdlc || can_data != pdata))
         stab <= stab + 1;
      if (frame_valid) vcyc <= vcyc + 1;
      if (frame_valid && frame_ready) begin
         xfers  <= xfers + 1;
         x_id   <= can_id;
         x_dlc  <= can_dlc;
         x_data <= can_data;
      end
      if (err_pulse) begin
         errs      <= errs + 1;
         last_code <= err_code;
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      rx_data  = b;
      rx_ready = 1'b1;
      repeat (hold) tick();
      rx_ready = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_nominal(input int hold, input logic [7:0] chk);
      send_byte(8'hAA, hold);
      send_byte(8'h01, hold);
      send_byte(8'h23, hold);
      send_byte(8'h02, hold);
      send_byte(8'h11, hold);
      send_byte(8'h22, hold);
`ifdef UART_FRAME_CHK_EN
      send_byte(chk, hold);
`else
      if (chk == 8'h00) tick();
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, x0, v0, s0, first;

      repeat (3) tick();
      check("rst_valid", frame_valid, 0);
      check("rst_id", can_id, 0);
      check("rst_dlc", can_dlc, 0);
      check("rst_data", can_data, 0);
      check("rst_errp", err_pulse, 0);
      check("rst_errc", err_code, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      repeat (2) tick();

      e0 = errs; x0 = xfers; v0 = vcyc;
      send_nominal(1, 8'h13);
      repeat (3) tick();
      check("nom_xfers", xfers - x0, 1);
      check("nom_vcyc", vcyc - v0, 1);
      check("nom_id", x_id, 11'h123);
      check("nom_dlc", x_dlc, 2);
      check("nom_data", x_data, 64'h2211);
      check("nom_errs", errs - e0, 0);
      check("nom_busy", busy, 0);

`ifdef UART_FRAME_CHK_EN
      e0 = errs; x0 = xfers;
      send_nominal(1, 8'h14);
      repeat (2) tick();
      check("chk_errs", errs - e0, 1);
      check("chk_code", last_code, 2);
      check("chk_xfers", xfers - x0, 0);
      send_nominal(1, 8'h13);
      repeat (3) tick();
      check("chk_next_xfers", xfers - x0, 1);
`endif

      e0 = errs; x0 = xfers;
      send_byte(8'hAA, 1);
      send_byte(8'h07, 1);
      send_byte(8'hFF, 1);
      send_byte(8'h09, 1);
      check("dlc_errs", errs - e0, 1);
      check("dlc_code", last_code, 1);
      check("dlc_busy", busy, 0);
      check("dlc_id", can_id, 11'h7FF);
      send_byte(8'h11, 1);
      send_byte(8'h22, 1);
      check("dlc_tail_busy", busy, 0);
      check("dlc_tail_errs", errs - e0, 1);
      check("dlc_xfers", xfers - x0, 0);

      e0 = errs;
      send_byte(8'hAA, 1);
      rx_data  = 8'h01;
      rx_ready = 1'b1;
      first = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 1) rx_ready = 1'b0;
         if (err_pulse && first == 0) first = k;
      end
      check("to_lat", first, 51);
      check("to_errs", errs - e0, 1);
      check("to_code", last_code, 3);
      check("to_busy", busy, 0);

      e0 = errs;
      send_byte(8'hAA, 1);
      send_byte(8'h01, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_errs", errs - e0, 0);

      e0 = errs; x0 = xfers; s0 = stab;
      frame_ready = 1'b0;
      send_byte(8'hAA, 1);
      send_byte(8'h00, 1);
      send_byte(8'h05, 1);
      send_byte(8'h00, 1);
`ifdef UART_FRAME_CHK_EN
      send_byte(8'h05, 1);
`endif
      repeat (2) tick();
      check("bp_valid", frame_valid, 1);
      check("bp_id", can_id, 11'h005);
      check("bp_dlc", can_dlc, 0);
      send_byte(8'h77, 1);
      check("ovr_errs", errs - e0, 1);
      check("ovr_code", last_code, 4);
      check("ovr_valid", frame_valid, 1);
      check("ovr_id", can_id, 11'h005);
      check("ovr_stab", stab - s0, 0);
      check("ovr_xfers", xfers - x0, 0);
      frame_ready = 1'b1;
      repeat (2) tick();
      check("bp_xfers", xfers - x0, 1);
      check("bp_xdata", x_data, 0);
      check("bp_done", frame_valid, 0);

      e0 = errs; x0 = xfers; v0 = vcyc;
      send_nominal(20, 8'h13);
      repeat (3) tick();
      check("lvl_xfers", xfers - x0, 1);
      check("lvl_vcyc", vcyc - v0, 1);
      check("lvl_id", x_id, 11'h123);
      check("lvl_dlc", x_dlc, 2);
      check("lvl_data", x_data, 64'h2211);
      check("lvl_errs", errs - e0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame sequencer behind the UART receiver in the UART-to-CAN bridge. It consumes received bytes (data bus plus data-ready level), hunts for a sync byte, and assembles a CAN frame request: 11-bit ID, DLC and up to 8 data bytes, optionally checksummed. It then hands the frame to the CAN transmit side over a valid/ready handshake. Malformed, stalled or overrun frames are dropped, and each drop is reported with an error code.

## Interface
- `TIMEOUT_CYCLES`, default 100000: inter-byte timeout in clock cycles, minimum 2.
- `SYNC_BYTE`, default 8'hAA: frame start marker.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte; valid while `rx_ready` is high.
- `rx_ready`  in  1  data-ready level from the receiver. It may stay high for several cycles.
- `frame_valid`  out  1  assembled frame available.
- `frame_ready`  in  1  CAN side accepts the frame.
- `can_id`  out  11  frame identifier.
- `can_dlc`  out  4  data length, 0..8.
- `can_data`  out  64  payload; byte k is in bits [8k+7:8k].
- `err_pulse`  out  1  one-cycle pulse when a frame is dropped.
- `err_code`  out  3  cause of the last drop; held until the next drop.
- `busy`  out  1  high in every state except HUNT.

## Operation
- **Byte event:** `rx_ready` is sampled into a 1-bit register. An event is a cycle where `rx_ready`=1 and the registered value is 0. Only one byte is taken per `rx_ready` high period.
- **States:** HUNT, ID_HI, ID_LO, DLC, DATA, CHK, ISSUE.
- **HUNT:** on an event with `rx_data`==`SYNC_BYTE`: go to ID_HI, clear `can_data`, clear the checksum accumulator. Any other byte is ignored silently.
- **ID_HI:** on an event, `can_id[10:8]` <= `rx_data[2:0]`. `rx_data[7:3]` is ignored. Go to ID_LO.
- **ID_LO:** on an event, `can_id[7:0]` <= `rx_data`. Go to DLC.
- **DLC:** on an event, if `rx_data` > 8: error BAD_DLC, go to HUNT.
  - Otherwise latch `can_dlc`, load the byte index with 0, and branch on the value:
  - DLC = 0: go to CHK, or to ISSUE if checksum is compiled out.
  - DLC > 0: go to DATA.
- **DATA:** on each event, store the byte at the current index and increment the index. After byte DLC-1, go to CHK (or ISSUE).
- **Checksum:** the accumulator is the XOR of the ID_HI, ID_LO, DLC and all data bytes as received.
- **CHK:** on an event, if `rx_data` equals the accumulator, go to ISSUE. Otherwise error CHECKSUM, go to HUNT.
- **ISSUE:** `frame_valid`=1. On `frame_valid`&&`frame_ready`, go to HUNT.
  - An event while in ISSUE drops that byte and raises error OVERRUN. The state does not change.
- **Error codes** (from package): 0 NONE, 1 BAD_DLC, 2 CHECKSUM, 3 TIMEOUT, 4 OVERRUN.
- **Timeout:** the counter runs in ID_HI, ID_LO, DLC, DATA and CHK.
  - It clears on every event and on entry to any of these states.
  - When it reaches `TIMEOUT_CYCLES`-1: error TIMEOUT, go to HUNT.
  - If a byte event and expiry occur in the same cycle, the byte wins: it is processed and the counter clears.
- **Output stability:** `can_id`, `can_dlc` and `can_data` change only in ID_HI..DATA. They are stable for the whole time `frame_valid` is high.

## Timing
- **Reset values:** state HUNT; `frame_valid`=0, `can_id`=0, `can_dlc`=0, `can_data`=0, `err_pulse`=0, `err_code`=0, `busy`=0. The edge register and timeout counter reset to 0.
- **Reset mid-frame:** the partial frame is discarded with no error pulse.
- **Byte latency:** a byte event in cycle N updates state and fields at the end of N.
- **Handshake:**
  - `frame_valid` is high from cycle N+1, where N is the event cycle of the final byte (CHK, or the last DATA/DLC byte).
  - If `frame_ready` is already high, the transfer completes in cycle N+1 and `frame_valid` is low at N+2.
  - `frame_valid`, once high, does not drop without a transfer.
- **Error pulse:** `err_pulse` is high exactly one cycle, the cycle after the causing event or expiry. `err_code` updates in that same cycle.
- **Sync after abort:** after an error, the controller is in HUNT from the next cycle. A SYNC byte arriving one event later starts a new frame.

## Configuration
- `UART_FRAME_CHK_EN` defined: the CHK state and accumulator exist, and the CHECKSUM error can occur.
- `UART_FRAME_CHK_EN` undefined: no checksum byte. The last DATA byte (or DLC=0) goes directly to ISSUE, and code 2 never occurs.

## Structure
- **Package `uart_frame_pkg`:** state enum, error-code constants, default `SYNC_BYTE`, maximum DLC constant (8).
- **Sub-module `uart_frame_timeout`:** the inter-byte counter, with inputs `clear` and `enable` and output `expired`, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- **Nominal frame:** bytes AA 01 23 02 11 22 13 with checksum on, `frame_ready`=1 -> one `frame_valid` cycle with `can_id`=0x123, `can_dlc`=2, `can_data`=0x0000_0000_0000_2211, no `err_pulse`.
- **Bad checksum:** same frame with CHK=0x14 -> `err_pulse` once, `err_code`=2, no `frame_valid`. A following good frame is accepted.
- **Bad DLC:** AA 07 FF 09 -> `err_code`=1, back in HUNT. The trailing data bytes are ignored until the next AA.
- **Timeout:** `TIMEOUT_CYCLES`=50; send AA 01, then idle 60 cycles -> `err_code`=3 exactly 50 cycles after the 01 event; `busy` low afterwards.
- **Backpressure and overrun:** hold `frame_ready`=0 after a DLC=0 frame (AA 00 05 00 05) and send one more byte -> outputs held stable, `err_code`=4. Asserting `frame_ready` then completes the transfer.
- **Long rx_ready level:** `rx_ready` held high 20 cycles per byte -> each byte counted once; the nominal frame results are identical.
